// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-side memory controller.
package dmem_pkg;

  typedef enum logic {
    StClear,
    StReady
  } dmem_state_e;

  localparam logic [31:0] MMIO_GPIO   = 32'h0000_0000;
  localparam logic [31:0] MMIO_CYCLES = 32'h0000_0004;
  localparam logic [31:0] MMIO_ERR    = 32'h0000_0008;

  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RANGE    = 1;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with write enable and an enabled, registered read port.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: zero-clearing sweep, sticky access errors, RAM port.
// Optional MMIO window (gpio, cycle counter, error W1C) enabled by DMEM_MMIO_EN.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        ready,
  output logic [1:0]  err,
  output logic [31:0] gpio_out
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  dmem_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    err_q, err_d, err_set, err_clr;
  logic          sel_ram_q, sel_ram_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic [31:0]   offset;
  logic          ram_hit, misalign, mmio_hit;

  // Unsigned wrap of the offset makes one compare cover both range bounds.
  assign offset   = dAddress - BASE_ADDR;
  assign ram_hit  = offset < RAM_BYTES;
  assign misalign = dAddress[1:0] != 2'b00;

`ifdef DMEM_MMIO_EN
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] mmio_off, mmio_rdata;

  assign mmio_off = dAddress - MMIO_BASE;
  assign mmio_hit = (mmio_off == MMIO_GPIO) || (mmio_off == MMIO_CYCLES) ||
                    (mmio_off == MMIO_ERR);

  always_comb begin
    mmio_rdata = 32'h0;
    if (mmio_off == MMIO_GPIO) begin
      mmio_rdata = gpio_q;
    end else if (mmio_off == MMIO_CYCLES) begin
      mmio_rdata = cycles_q;
    end else if (mmio_off == MMIO_ERR) begin
      mmio_rdata = {30'h0, err_q};
    end
  end

  assign gpio_out = gpio_q;
`else
  logic [31:0] unused_mmio;
  assign unused_mmio = MMIO_BASE ^ MMIO_GPIO ^ MMIO_CYCLES ^ MMIO_ERR;
  assign mmio_hit    = 1'b0;
  assign gpio_out    = 32'h0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_ram_d = sel_ram_q;
    rdata_d   = rdata_q;
    err_set   = 2'b00;
    err_clr   = 2'b00;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = offset[AW+1:2];
    ram_wdata = dWriteData;
`ifdef DMEM_MMIO_EN
    gpio_d    = gpio_q;
    cycles_d  = cycles_q;
`endif
    unique case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_addr  = idx_q;
        ram_wdata = 32'h0;
        idx_d     = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = StReady;
        end
      end
      StReady: begin
`ifdef DMEM_MMIO_EN
        cycles_d = cycles_q + 32'd1;
`endif
        if (MemRead || MemWrite) begin
          if (misalign) begin
            err_set[ERR_MISALIGN] = 1'b1;
          end else if (ram_hit) begin
            // A simultaneous read is dropped so the write owns the single port.
            if (MemWrite) begin
              ram_we = 1'b1;
            end else begin
              ram_re    = 1'b1;
              sel_ram_d = 1'b1;
            end
`ifdef DMEM_MMIO_EN
          end else if (mmio_hit) begin
            if (MemWrite) begin
              if (mmio_off == MMIO_GPIO) begin
                gpio_d = dWriteData;
              end else if (mmio_off == MMIO_ERR) begin
                err_clr = dWriteData[1:0];
              end
            end else begin
              sel_ram_d = 1'b0;
              rdata_d   = mmio_rdata;
            end
`endif
          end else begin
            err_set[ERR_RANGE] = 1'b1;
            if (!MemWrite) begin
              sel_ram_d = 1'b0;
              rdata_d   = 32'h0;
            end
          end
        end
      end
      default: ;
    endcase
    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      idx_q     <= '0;
      err_q     <= 2'b00;
      sel_ram_q <= 1'b0;
      rdata_q   <= 32'h0;
`ifdef DMEM_MMIO_EN
      gpio_q    <= 32'h0;
      cycles_q  <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      sel_ram_q <= sel_ram_d;
      rdata_q   <= rdata_d;
`ifdef DMEM_MMIO_EN
      gpio_q    <= gpio_d;
      cycles_q  <= cycles_d;
`endif
    end
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign dReadData = sel_ram_q ? ram_rdata : rdata_q;
  assign ready     = state_q == StReady;
  assign err       = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl; MMIO checks compiled with DMEM_MMIO_EN.
module tb_data_memory_ctrl;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO  = 32'hFFFF_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dAddress = 32'h0;
  logic [31:0] dWriteData = 32'h0;
  logic [31:0] dReadData;
  logic        ready;
  logic [1:0]  err;
  logic [31:0] gpio_out;

  always #5 clk = ~clk;

  data_memory_ctrl #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .MMIO_BASE  (MMIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .dAddress  (dAddress),
    .dWriteData(dWriteData),
    .dReadData (dReadData),
    .ready     (ready),
    .err       (err),
    .gpio_out  (gpio_out)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [31:0] gpio;
    bit          chk_rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] m_mem [int];
  logic [31:0] m_rd;
  logic [1:0]  m_err;
  logic [31:0] m_gpio;
  bit          m_rd_known;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mem.delete();
    m_rd       = 32'h0;
    m_err      = 2'b00;
    m_gpio     = 32'h0;
    m_rd_known = 1'b1;
  endtask

  // Caller sits just after a posedge; the access is sampled on the next one.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_eq("rst_rdata", dReadData, 32'h0);
    check_eq("rst_ready", {31'h0, ready}, 32'h0);
    check_eq("rst_err", {30'h0, err}, 32'h0);
    check_eq("rst_gpio", gpio_out, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit clearing);
    exp_t e;
    int   idx;
    if (!clearing && (rd || wr)) begin
      if (addr[1:0] != 2'b00) begin
        m_err[0] = 1'b1;
      end else if ((addr - BASE) < 32'(4 * DEPTH)) begin
        idx = int'((addr - BASE) >> 2);
        if (wr) begin
          m_mem[idx] = data;
        end else begin
          m_rd       = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
          m_rd_known = 1'b1;
        end
`ifdef DMEM_MMIO_EN
      end else if (addr == MMIO) begin
        if (wr) m_gpio = data;
        else begin
          m_rd       = m_gpio;
          m_rd_known = 1'b1;
        end
      end else if (addr == MMIO + 32'd4) begin
        if (!wr) m_rd_known = 1'b0;
      end else if (addr == MMIO + 32'd8) begin
        if (wr) m_err = m_err & ~data[1:0];
        else begin
          m_rd       = {30'h0, m_err};
          m_rd_known = 1'b1;
        end
`endif
      end else begin
        m_err[1] = 1'b1;
        if (!wr) begin
          m_rd       = 32'h0;
          m_rd_known = 1'b1;
        end
      end
    end
    sb.push_back('{rdata: m_rd, err: m_err, gpio: m_gpio, chk_rd: m_rd_known});
    MemRead    = rd;
    MemWrite   = wr;
    dAddress   = addr;
    dWriteData = data;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    e = sb.pop_front();
    if (e.chk_rd) check_eq({tag, "_rdata"}, dReadData, e.rdata);
    check_eq({tag, "_err"}, {30'h0, err}, {30'h0, e.err});
    check_eq({tag, "_gpio"}, gpio_out, e.gpio);
  endtask

  // Counts sweep edges from first_edge through DEPTH; ready must rise on the last.
  task automatic sweep(input string tag, input int first_edge);
    bit early = 1'b0;
    for (int i = first_edge; i <= int'(DEPTH); i++) begin
      @(posedge clk);
      #1;
      if (i < int'(DEPTH) && ready) early = 1'b1;
    end
    check_eq({tag, "_early"}, {31'h0, early}, 32'h0);
    check_eq({tag, "_rise"}, {31'h0, ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    model_reset();
    do_reset();
    sweep("sweep1", 1);

    access("rd_zero", 1, 0, BASE + 32'h40, 32'h0, 0);
    access("wr8", 0, 1, BASE + 32'h8, 32'hDEAD_BEEF, 0);
    access("rd8", 1, 0, BASE + 32'h8, 32'h0, 0);
    access("wr0", 0, 1, BASE, 32'h1234_5678, 0);
    access("mis_wr", 0, 1, BASE + 32'h2, 32'hFFFF_FFFF, 0);
    access("rd0", 1, 0, BASE, 32'h0, 0);
    access("mis_rd", 1, 0, BASE + 32'h1, 32'h0, 0);
    access("oor_rd", 1, 0, BASE + 32'd4096, 32'h0, 0);
    access("rd8b", 1, 0, BASE + 32'h8, 32'h0, 0);
    access("rdwr4", 1, 1, BASE + 32'h4, 32'h5, 0);
    access("rd4", 1, 0, BASE + 32'h4, 32'h0, 0);
    access("wr_last", 0, 1, BASE + 32'd4092, 32'hCAFE_0001, 0);
    access("rd_last", 1, 0, BASE + 32'd4092, 32'h0, 0);
    access("oor_low", 1, 0, BASE - 32'd4, 32'h0, 0);
    access("oor_wr", 0, 1, BASE + 32'd8192, 32'h7777_7777, 0);
    access("rd0b", 1, 0, BASE, 32'h0, 0);
    access("mmio_gpio_wr", 0, 1, MMIO, 32'hA5, 0);
    access("mmio_gpio_rd", 1, 0, MMIO, 32'h0, 0);
    access("mmio_err_rd", 1, 0, MMIO + 32'd8, 32'h0, 0);
    access("mmio_err_clr", 0, 1, MMIO + 32'd8, 32'h3, 0);
    access("mmio_err_rd2", 1, 0, MMIO + 32'd8, 32'h0, 0);
`ifdef DMEM_MMIO_EN
    access("cyc1", 1, 0, MMIO + 32'd4, 32'h0, 0);
    v1 = dReadData;
    idle(9);
    access("cyc2", 1, 0, MMIO + 32'd4, 32'h0, 0);
    v2 = dReadData;
    check_eq("cycle_delta", v2 - v1, 32'd10);
    access("cyc_wr", 0, 1, MMIO + 32'd4, 32'h0, 0);
    access("rd8c", 1, 0, BASE + 32'h8, 32'h0, 0);
`endif

    // Reset mid-sweep, then accesses during CLEAR must be ignored.
    do_reset();
    idle(100);
    check_eq("clear100_ready", {31'h0, ready}, 32'h0);
    do_reset();
    access("clr_mis", 0, 1, BASE + 32'h2, 32'h1, 1);
    access("clr_oor", 1, 0, BASE + 32'd4096, 32'h0, 1);
    access("clr_rd", 1, 0, BASE + 32'h8, 32'h0, 1);
    sweep("sweep2", 4);
    access("rd8_cleared", 1, 0, BASE + 32'h8, 32'h0, 0);
    access("rd0_cleared", 1, 0, BASE, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
